// File: rtl/rca_seq_ctrl.sv
// Wide adder sequenced over one shared 4-bit ripple slice, LSB nibble first; optional subtract via RCA_SEQ_SUB_EN.
// Latency: START edge k -> DONE high in the cycle after edge k+NIBBLES; READY again at edge k+NIBBLES+1.
// Backpressure: START is taken only while READY=1; requests while BUSY/DONE are dropped, not queued.
module rca_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   start_i,
`ifdef RCA_SEQ_SUB_EN
    input  logic                   sub_i,
`endif
    input  logic [4*NIBBLES-1:0]   a_i,
    input  logic [4*NIBBLES-1:0]   b_i,
    output logic                   ready_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [4*NIBBLES-1:0]   sum_o,
    output logic                   carry_o
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DONE_S = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_sh_q;
    logic [W-1:0]    b_sh_q;
    logic [W-1:0]    psum_q;
    logic [W-1:0]    sum_q;
    logic [CW-1:0]   cnt_q;
    logic            c_q;
    logic            carry_q;
    logic            ready_q;
    logic            busy_q;
    logic            done_q;

    logic            op_sub;
    logic [4:0]      nsum;
    logic [W-1:0]    psum_d;

`ifdef RCA_SEQ_SUB_EN
    assign op_sub = sub_i;
`else
    assign op_sub = 1'b0;
`endif

    assign nsum   = {1'b0, a_sh_q[3:0]} + {1'b0, b_sh_q[3:0]} + {4'd0, c_q};
    // New nibble enters at the MSB so the LSB nibble ends up at the bottom after NIBBLES shifts.
    assign psum_d = (psum_q >> 4) | (W'(nsum[3:0]) << (W - 4));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        // Subtract is A + ~B + 1: invert B once here and seed the carry.
                        a_sh_q  <= a_i;
                        b_sh_q  <= op_sub ? ~b_i : b_i;
                        c_q     <= op_sub;
                        cnt_q   <= '0;
                        psum_q  <= '0;
                        state_q <= RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    psum_q <= psum_d;
                    c_q    <= nsum[4];
                    a_sh_q <= a_sh_q >> 4;
                    b_sh_q <= b_sh_q >> 4;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        sum_q   <= psum_d;
                        carry_q <= nsum[4];
                        state_q <= DONE_S;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE_S: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign sum_o   = sum_q;
    assign carry_o = carry_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Bench for rca_seq_ctrl (NIBBLES=4): vector table, hand sequences for multi-cycle corners, and random ops vs an arithmetic model.
module tb_rca_seq_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          sub = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          ready, busy, done, carry;
    logic [W-1:0]  sum;

    rca_seq_ctrl #(.NIBBLES(N)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start),
`ifdef RCA_SEQ_SUB_EN
        .sub_i   (sub),
`endif
        .a_i     (a),
        .b_i     (b),
        .ready_o (ready),
        .busy_o  (busy),
        .done_o  (done),
        .sum_o   (sum),
        .carry_o (carry)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] prev_sum = '0;
    logic         prev_carry = 1'b0;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] es;
        logic         ec;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Model: plain wide arithmetic on the operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                         output logic [W-1:0] ms, output logic mc);
        logic [W:0] r;
        if (msub) begin
            ms = ma - mb;
            mc = (ma >= mb);
        end else begin
            r  = {1'b0, ma} + {1'b0, mb};
            ms = r[W-1:0];
            mc = r[W];
        end
    endtask

    // One full operation starting from IDLE at a negedge; optionally fires a stray START mid-RUN.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsub,
                          input logic inject, input logic [W-1:0] es, input logic ec, input string tag);
        int  n;
        int  busy_n;
        bit  seen;
        n = 0; busy_n = 0; seen = 0;
        chk({tag, "_ready_pre"}, ready, 1);
        start = 1'b1; a = ta; b = tb_v; sub = tsub;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (inject && n == 2) begin
                start = 1'b1; a = 16'hAAAA; b = 16'h5555;
            end
            if (inject && n == 3) start = 1'b0;
            if (busy) begin
                busy_n++;
                chk({tag, "_sum_hold"}, sum, prev_sum);
                chk({tag, "_carry_hold"}, carry, prev_carry);
            end
            if (done) seen = 1;
        end
        chk({tag, "_latency"}, n, N + 1);
        chk({tag, "_busy_cycles"}, busy_n, N);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_carry"}, carry, ec);
        prev_sum = es;
        prev_carry = ec;
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_ready_back"}, ready, 1);
    endtask

    initial begin
        vec_t tbl[6];
        logic [W-1:0] rs;
        logic         rc;
        int           last;
        int           dcnt;
        tbl[0] = '{16'h1234, 16'h0FCD, 16'h2201, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        tbl[2] = '{16'h0F0F, 16'h00F1, 16'h1000, 1'b0};
        tbl[3] = '{16'h8000, 16'h8000, 16'h0000, 1'b1};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
        tbl[5] = '{16'h0000, 16'h0000, 16'h0000, 1'b0};

        #12;
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_carry", carry, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_op(tbl[i].va, tbl[i].vb, 1'b0, 1'b0, tbl[i].es, tbl[i].ec, $sformatf("vec%0d", i));

        // Stray START during RUN must be dropped; SUM holds the previous result meanwhile.
        run_op(16'h0001, 16'h0002, 1'b0, 1'b1, 16'h0003, 1'b0, "ignore");
        @(negedge clk);
        chk("ignore_idle_ready", ready, 1);
        chk("ignore_no_extra_busy", busy, 0);

        // Back-to-back with START held high.
        start = 1'b1; a = 16'h0F0F; b = 16'h00F1; sub = 1'b0;
        last = -1; dcnt = 0;
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            if (done) begin
                dcnt++;
                chk("b2b_sum", sum, 16'h1000);
                chk("b2b_carry", carry, 0);
                if (last >= 0) chk("b2b_spacing", n - last, N + 2);
                last = n;
            end
        end
        start = 1'b0;
        chk("b2b_done_count", dcnt, 6);
        chk("b2b_ready_end", ready, 1);
        prev_sum = 16'h1000; prev_carry = 1'b0;
        @(negedge clk);

        // Reset in the middle of RUN.
        start = 1'b1; a = 16'h8000; b = 16'h8000;
        @(negedge clk);
        start = 1'b0;
        chk("abort_busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", ready, 1);
        chk("abort_busy_clr", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, 0);
        chk("abort_carry", carry, 0);
        dcnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);
        prev_sum = '0; prev_carry = 1'b0;
        run_op(16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, "after_abort");

`ifdef RCA_SEQ_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, "sub_borrow");
        run_op(16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, "sub_noborrow");
        run_op(16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, "sub_equal");
`endif

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rsub;
            logic         rinj;
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 5 == 0) rb = ~ra;
`ifdef RCA_SEQ_SUB_EN
            rsub = 1'($urandom_range(0, 1));
`else
            rsub = 1'b0;
`endif
            rinj = 1'($urandom_range(0, 1));
            model(ra, rb, rsub, rs, rc);
            run_op(ra, rb, rsub, rinj, rs, rc, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rca_seq_ctrl.md
Name: rca_seq_ctrl

Overview:
Sequencer that computes wide additions on a single shared 4-bit ripple-carry adder slice, one nibble per clock, LSB nibble first.
- Operands are latched on a START handshake.
- A carry register chains the nibbles.
- The full-width SUM and final CARRY are published with a one-cycle DONE pulse.
- Sits between a control FSM / register file and the nibble adder datapath. Trades latency for area versus a full-width ripple chain.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to CLK externally
START  input  1  request new operation; sampled only when READY=1
A  input  W  operand A, sampled on the START edge
B  input  W  operand B, sampled on the START edge
READY  output  1  high in IDLE only
BUSY  output  1  high while nibbles are being processed (RUN)
DONE  output  1  one-cycle pulse, result valid
SUM  output  W  result register; holds the last completed result
CARRY  output  1  carry out of the top nibble of the last completed result

Behaviour:
- Reset (RST_N=0, asynchronous) puts the block in these values:
  - state=IDLE, READY=1, BUSY=0, DONE=0, SUM=0, CARRY=0.
  - Internal operand shift registers, partial-sum register, carry register and nibble counter are all cleared.
- State IDLE:
  - On a rising edge with START=1, latch A and B into operand shift registers, clear the carry register, set CNT=0, go to RUN.
  - START=0 stays in IDLE.
- State RUN, one nibble per edge:
  - nsum = A_sh[3:0] + B_sh[3:0] + c (5-bit result).
  - The low 4 bits shift into the partial-sum register from the top (MSB side).
  - c <= nsum[4].
  - Operand registers shift right by 4.
  - CNT increments.
- On the edge processing nibble NIBBLES-1 (CNT=NIBBLES-1):
  - SUM <= final partial sum.
  - CARRY <= nsum[4].
  - Go to DONE_S.
- State DONE_S:
  - DONE=1 for exactly one cycle.
  - The next edge returns unconditionally to IDLE.
- Latency:
  - START sampled at edge k; DONE high in the cycle after edge k+NIBBLES.
  - READY returns at edge k+NIBBLES+1.
  - Back-to-back throughput is one operation per NIBBLES+2 cycles.
- START while BUSY or DONE=1 is ignored; no queuing, and operand inputs are don't-care.
- SUM/CARRY do not change during RUN; they show the previous result until the completing edge.
- Arithmetic is unsigned modulo 2^W; overflow is reported only via CARRY.
- NIBBLES=1:
  - RUN lasts one edge and CNT is effectively unused.
  - Any counter width must be at least 1 bit.
- Reset mid-RUN aborts the operation:
  - no DONE pulse;
  - SUM/CARRY return to 0;
  - the next START is accepted normally once RST_N is high.
- Only these encodings are reachable: IDLE, RUN, DONE_S. Any illegal state encoding recovers to IDLE on the next edge.

Optional Feature:
Macro RCA_SEQ_SUB_EN.
- Defined:
  - Adds input port SUB (1 bit), sampled with START.
  - If SUB=1:
    - each B nibble is bitwise inverted before the add;
    - the carry register initialises to 1 at START;
    - the result is A-B mod 2^W;
    - CARRY=1 means no borrow (A>=B), CARRY=0 means borrow.
  - If SUB=0, behaviour is identical to add.
- Undefined:
  - No SUB port.
  - Add only; the carry register always initialises to 0.

Test Plan:
- NIBBLES=4, START with A=0x1234, B=0x0FCD -> DONE pulse exactly 5 cycles after the START edge; SUM=0x2201, CARRY=0; BUSY high for 4 cycles.
- A=0xFFFF, B=0x0001 -> SUM=0x0000, CARRY=1; check the carry ripples through all 4 nibbles.
- Start A=0x0001, B=0x0002, then pulse START with A=0xAAAA, B=0x5555 during RUN -> second request ignored; SUM=0x0003, CARRY=0; SUM holds its old value throughout RUN.
- Start A=0x8000, B=0x8000, assert RST_N=0 after 2 RUN cycles -> outputs immediately reset values, no DONE; next START A=0x0010, B=0x0020 -> SUM=0x0030.
- Back-to-back: hold START=1 continuously with A=0x0F0F, B=0x00F1 -> one accepted op per 6 cycles; each DONE gives SUM=0x1000, CARRY=0.
- With RCA_SEQ_SUB_EN, SUB=1: A=0x0005, B=0x0007 -> SUM=0xFFFE, CARRY=0. Also A=0x0007, B=0x0005 -> SUM=0x0002, CARRY=1.
